// File: rtl/fsm_job_dispatcher.sv
// fsm_job_dispatcher: issues one start pulse per job to a single worker, waits for each done edge
// under a watchdog, and reports batch completion with a one-cycle status pulse.
module fsm_job_dispatcher #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             cmpl_valid,
  output logic             cmpl_ok,
  output logic [CNT_W-1:0] jobs_done,
  output logic             timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAPW, REPORT} state_t;
  state_t           state_q, state_d;
  logic             done_q;
  logic [CNT_W-1:0] count_q, count_d, jobs_q, jobs_d, jobs_inc;
  logic             ok_q, ok_d, terr_q, terr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             done_ev;
  assign done_ev     = done & ~done_q;
  assign jobs_inc    = jobs_q + CNT_W'(1);
  assign req_ready   = (state_q == IDLE) & ~rst;
  assign start       = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign cmpl_valid  = (state_q == REPORT);
  assign cmpl_ok     = ok_q;
  assign jobs_done   = jobs_q;
  assign timeout_err = terr_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    jobs_d  = jobs_q;
    ok_d    = ok_q;
    terr_d  = terr_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (req_valid & req_ready) begin
        count_d = req_count;
        jobs_d  = '0;
        ok_d    = (req_count == '0);
        terr_d  = 1'b0;
        state_d = (req_count == '0) ? REPORT : ISSUE;
      end
      ISSUE: begin
        timer_d = TW'(TIMEOUT);
        state_d = WAIT;
      end
      WAIT: if (done_ev) begin
        jobs_d = jobs_inc;
        if (jobs_inc == count_q) begin
          ok_d    = 1'b1;
          state_d = REPORT;
        end else begin
          gap_d   = GW'(GAP);
          state_d = (GAP > 0) ? GAPW : ISSUE;
        end
      end else if (timer_q == TW'(1)) begin
        terr_d  = 1'b1;
        state_d = REPORT;
      end else begin
        timer_d = timer_q - TW'(1);
      end
      GAPW: begin
        gap_d   = gap_q - GW'(1);
        state_d = (gap_q <= GW'(1)) ? ISSUE : GAPW;
      end
      REPORT: state_d = IDLE;
      default: begin
        state_d = IDLE;
        count_d = '0;
        jobs_d  = '0;
        ok_d    = 1'b0;
        terr_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      count_q <= '0;
      jobs_q  <= '0;
      ok_q    <= 1'b0;
      terr_q  <= 1'b0;
      timer_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      count_q <= count_d;
      jobs_q  <= jobs_d;
      ok_q    <= ok_d;
      terr_q  <= terr_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
    end
  end
endmodule

// File: tb/tb_fsm_job_dispatcher.sv
// tb_fsm_job_dispatcher: randomized batches against an event-time reference model of the dispatcher.
module tb_fsm_job_dispatcher;
  localparam int CNT_W = 8, TIMEOUT = 16, GAP = 1;
  logic clk = 0, rst = 1, req_valid = 0, done = 0;
  logic [CNT_W-1:0] req_count = '0;
  logic req_ready, start, busy, cmpl_valid, cmpl_ok, timeout_err;
  logic [CNT_W-1:0] jobs_done;
  int cyc = 0, pass_n = 0, tot_n = 0, pending = -1;
  int dq[$];
  string obs;
  fsm_job_dispatcher #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count), .req_ready(req_ready),
    .start(start), .done(done), .busy(busy), .cmpl_valid(cmpl_valid), .cmpl_ok(cmpl_ok),
    .jobs_done(jobs_done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Worker: on start, done drops and rises d cycles later; d=0 never rises, d<0 leaves done untouched
  task automatic step();
    int d;
    @(negedge clk);
    if (start === 1'b1) begin
      d = dq.size() > 0 ? dq.pop_front() : 0;
      if (d >= 0) done = 1'b0;
      pending = (d > 0) ? cyc + d : -1;
    end else if (cyc == pending) done = 1'b1;
  endtask
  function automatic string model(input int n, input int d[$]);
    int t = 1, j = 0, c = 0, ok = 0, terr = 0;
    string s = "";
    if (n == 0) begin c = 1; ok = 1; end
    for (int i = 0; i < n; i++) begin
      s = {s, $sformatf("s%0d ", t)};
      if (d[i] <= 0) begin c = t + TIMEOUT + 1; terr = 1; break; end
      j++;
      if (j == n) begin c = t + d[i] + 1; ok = 1; break; end
      t += d[i] + 1 + GAP;
    end
    return {s, $sformatf("c%0d ok%0d j%0d t%0d h%0d %0d %0d", c, ok, j, terr, ok, j, terr)};
  endfunction
  task automatic run_batch(input int n, input bit poke, output int a);
    int t = 0, post = 0;
    bit seen = 0;
    obs = "";
    step();
    while (req_ready !== 1'b1 && t < 50) begin step(); t++; end
    req_valid = 1'b1;
    req_count = CNT_W'(n);
    a = cyc;
    for (int i = 0; i < 400 && post < 4; i++) begin
      step();
      req_valid = poke && (cyc == a + 2);
      if (poke && cyc == a + 2) req_count = CNT_W'(7);
      if (start) obs = {obs, $sformatf("s%0d ", cyc - a)};
      if (cmpl_valid) begin
        obs = {obs, $sformatf("c%0d ok%0d j%0d t%0d", cyc - a, cmpl_ok, jobs_done, timeout_err)};
        seen = 1;
      end
      if (seen) post++;
    end
    req_valid = 1'b0;
    if (!seen) obs = {obs, "nocmpl "};
    obs = {obs, $sformatf(" h%0d %0d %0d", cmpl_ok, jobs_done, timeout_err)};
  endtask
  task automatic test_reset();
    rst = 1; req_valid = 1; req_count = '0;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      tot_n++;
      if ({busy, start, cmpl_valid, cmpl_ok, timeout_err, req_ready, jobs_done} !== '0)
        $display("FAIL reset_outputs: got %b want 0", {busy, start, cmpl_valid, cmpl_ok, timeout_err, req_ready, jobs_done});
      else pass_n++;
    end
    rst = 0;
    #1;
    tot_n++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else pass_n++;
    step();
    req_valid = 0;
    tot_n++;
    if ({cmpl_valid, cmpl_ok, start, req_ready, jobs_done} !== {4'b1100, CNT_W'(0)})
      $display("FAIL reset_accept: got %b want 1100_0", {cmpl_valid, cmpl_ok, start, req_ready, jobs_done});
    else pass_n++;
    step();
    tot_n++;
    if ({busy, cmpl_valid, cmpl_ok} !== 3'b001)
      $display("FAIL reset_after: got %b want 001", {busy, cmpl_valid, cmpl_ok});
    else pass_n++;
  endtask
  task automatic test_normal();
    int a;
    string e;
    dq = '{4, 4, 4};
    e = model(3, dq);
    run_batch(3, 0, a);
    tot_n++;
    if (obs != e) $display("FAIL normal: got '%s' want '%s'", obs, e); else pass_n++;
  endtask
  task automatic test_zero();
    int a;
    string e;
    dq = {};
    e = model(0, dq);
    run_batch(0, 0, a);
    tot_n++;
    if (obs != e) $display("FAIL zero: got '%s' want '%s'", obs, e); else pass_n++;
  endtask
  task automatic test_timeout();
    int a, t = 0;
    string e;
    dq = '{0, 0};
    e = model(2, dq);
    run_batch(2, 0, a);
    tot_n++;
    if (obs != e) $display("FAIL timeout: got '%s' want '%s'", obs, e); else pass_n++;
    repeat (5) step();
    tot_n++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err); else pass_n++;
    dq = '{2};
    while (req_ready !== 1'b1 && t < 50) begin step(); t++; end
    req_valid = 1; req_count = CNT_W'(1);
    step();
    req_valid = 0;
    tot_n++;
    if ({timeout_err, busy, start, jobs_done} !== {3'b011, CNT_W'(0)})
      $display("FAIL timeout_clear: got %b want 011_0", {timeout_err, busy, start, jobs_done});
    else pass_n++;
    repeat (6) step();
  endtask
  task automatic test_boundary();
    int a;
    string e;
    dq = '{TIMEOUT, TIMEOUT};
    e = model(2, dq);
    run_batch(2, 0, a);
    tot_n++;
    if (obs != e) $display("FAIL boundary_last_cycle: got '%s' want '%s'", obs, e); else pass_n++;
    dq = '{3, -1};
    e = model(2, dq);
    run_batch(2, 0, a);
    tot_n++;
    if (obs != e) $display("FAIL held_done: got '%s' want '%s'", obs, e); else pass_n++;
    done = 0;
    step();
    done = 1;
    repeat (3) step();
    tot_n++;
    if ({busy, start, cmpl_valid, jobs_done} !== {3'b000, CNT_W'(1)})
      $display("FAIL idle_done_edge: got %b want 000_1", {busy, start, cmpl_valid, jobs_done});
    else pass_n++;
    done = 0;
  endtask
  task automatic test_busy_req();
    int a;
    string e;
    dq = '{2, 5, 3};
    e = model(3, dq);
    run_batch(3, 1, a);
    tot_n++;
    if (obs != e) $display("FAIL busy_req: got '%s' want '%s'", obs, e); else pass_n++;
    step();
    tot_n++;
    if ({busy, req_ready} !== 2'b01) $display("FAIL busy_req_idle: got %b want 01", {busy, req_ready}); else pass_n++;
  endtask
  task automatic test_reset_mid();
    int t = 0, bad = 0;
    dq = '{3, 3, 3, 3};
    step();
    while (req_ready !== 1'b1 && t < 50) begin step(); t++; end
    req_valid = 1; req_count = CNT_W'(4);
    step();
    req_valid = 0;
    t = 0;
    while (jobs_done !== CNT_W'(1) && t < 100) begin step(); t++; end
    rst = 1;
    dq = {};
    pending = -1;
    step();
    tot_n++;
    if (t >= 100 || {busy, start, cmpl_valid, cmpl_ok, timeout_err, req_ready, jobs_done} !== '0)
      $display("FAIL reset_mid: got %b want 0 (wait %0d)", {busy, start, cmpl_valid, cmpl_ok, timeout_err, req_ready, jobs_done}, t);
    else pass_n++;
    rst = 0;
    repeat (20) begin step(); if (cmpl_valid || start || busy) bad++; end
    tot_n++;
    if (bad != 0) $display("FAIL reset_mid_quiet: got %0d active cycles want 0", bad); else pass_n++;
  endtask
  task automatic test_random();
    int a, n;
    int l[$];
    string e;
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, 5);
      l = {};
      for (int i = 0; i < n; i++) l.push_back($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, TIMEOUT));
      repeat ($urandom_range(0, 3)) step();
      dq = l;
      e = model(n, l);
      run_batch(n, $urandom_range(0, 1) == 1 && n > 0, a);
      tot_n++;
      if (obs != e) $display("FAIL random_%0d: got '%s' want '%s'", k, obs, e); else pass_n++;
    end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_timeout();
    test_boundary();
    test_busy_req();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/fsm_job_dispatcher.md
# fsm_job_dispatcher

Initiator-side controller for start/done worker state machines. It accepts a batch request (a job count) over a valid/ready handshake and issues one `start` pulse per job to a single worker. It waits for each job's `done`, aborts the batch on a watchdog timeout, and reports batch completion with a one-cycle status pulse. It sits between a host/sequencer and one worker FSM.

## Interface
- `CNT_W`, default 8: width of the job count and the completed-job counter; must be ≥1.
- `TIMEOUT`, default 16: WAIT cycles allowed per job before abort; must be ≥1.
- `GAP`, default 1: idle cycles between a `done` and the next `start`; must be ≥0.

- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: batch request valid.
- `req_count` in CNT_W: number of jobs in the batch.
- `req_ready` out 1: dispatcher can accept a request.
- `start` out 1: one-cycle start pulse to the worker.
- `done` in 1: worker done, treated as a level; only its rising edge counts.
- `busy` out 1: a batch is in progress.
- `cmpl_valid` out 1: one-cycle batch-complete pulse.
- `cmpl_ok` out 1: 1 means all jobs finished; 0 means the batch was aborted by timeout.
- `jobs_done` out CNT_W: jobs completed in the current or last batch.
- `timeout_err` out 1: sticky timeout flag.

## Operation
- States: IDLE, ISSUE, WAIT, GAPW, REPORT.
- Done event: `done_ev = done & ~done_q`. `done_q` is `done` registered, reset to 0.
  - A `done` level held over from the previous job is never counted.
- Moore outputs:
  - `req_ready` = (state==IDLE) & ~rst.
  - `start` = (state==ISSUE).
  - `busy` = (state!=IDLE).
  - `cmpl_valid` = (state==REPORT).
- IDLE:
  - On `req_valid & req_ready`: latch `req_count`, clear `jobs_done`, `cmpl_ok` and `timeout_err`.
  - Then go to REPORT if the count is 0, otherwise to ISSUE.
- ISSUE: `start` is high for exactly this cycle. Load the timer with TIMEOUT. Go to WAIT.
- WAIT: the timer decrements on each cycle without `done_ev`.
  - On `done_ev`: increment `jobs_done`.
    - If the new value equals the latched count, set `cmpl_ok`=1 and go to REPORT.
    - Otherwise go to GAPW if GAP>0, else to ISSUE.
  - On the TIMEOUT-th consecutive WAIT cycle with no `done_ev`: set `timeout_err`=1, keep `cmpl_ok`=0, go to REPORT.
  - If `done_ev` and timer expiry fall on the same cycle, `done_ev` wins.
- GAPW: stay GAP cycles, then go to ISSUE.
- REPORT: one cycle, then go to IDLE.
- `cmpl_ok`, `jobs_done` and `timeout_err` hold after REPORT until the next request is accepted.
- `done_ev` outside WAIT is ignored: it is not counted and causes no state change.
- `req_valid` while `busy` is not accepted. The requester must hold `req_valid` until it sees `req_ready`.
- `jobs_done` never exceeds the latched count, so no wrap is possible. The timer width is $clog2(TIMEOUT+1).
- Illegal state encodings return to IDLE with all status outputs cleared.

## Timing
- Reset values: `start`, `busy`, `cmpl_valid`, `cmpl_ok`, `timeout_err` = 0; `jobs_done` = 0.
  - `req_ready` is 0 while `rst` is high and 1 on the first cycle after.
- Reset mid-batch: on the cycle after the `rst` edge, state is IDLE and all outputs are at reset values. No `cmpl_valid` is produced.
- Accept at cycle A:
  - `start` is high in cycle A+1.
  - With a count of 0, `cmpl_valid` is high in A+1 and `start` never pulses.
- Latency after `start` in cycle T: a worker whose `done` rises in T+k produces `done_ev` in cycle T+k.
  - The next `start` is in T+k+1+GAP.
  - Or `cmpl_valid` is in T+k+1 for the last job.
- Timeout: with `start` in T and no `done_ev`, REPORT (`cmpl_valid`) is in T+TIMEOUT+1.

## Test plan
- Reset: hold `rst` 2 cycles with `req_valid`=1 -> all outputs 0, `req_ready`=0 during reset, `req_ready`=1 and request accepted on the first post-reset cycle.
- Normal batch: `req_count`=3, worker `done` rises 4 cycles after each `start` and stays high until the next `start`, defaults -> 3 `start` pulses 6 cycles apart, a single `cmpl_valid` 5 cycles after the third `start`, `cmpl_ok`=1, `jobs_done`=3, `timeout_err`=0.
- Zero count: `req_count`=0 -> no `start`, `cmpl_valid` in the cycle after accept, `cmpl_ok`=1, `jobs_done`=0.
- Timeout: `req_count`=2, `done` held low, TIMEOUT=16 -> one `start` at T, `cmpl_valid` at T+17, `cmpl_ok`=0, `jobs_done`=0, `timeout_err`=1 until the next accept.
- Boundary: `done` rises exactly on the 16th WAIT cycle -> job counted, no timeout; `done` held high through a following ISSUE/WAIT with no new edge -> not counted; spurious `done` edge in IDLE -> ignored.
- Mid-batch disruption: `req_valid` pulsed while `busy` -> not accepted; `rst` asserted after the first `done_ev` of a 4-job batch -> IDLE the next cycle, no `cmpl_valid`, `jobs_done`=0.
